serial_parallel_receiver: RTL

- Serial-in / parallel-out receiver. It is the receive end of the serial link driven by the team's BUS_WIDTH shifter with parallel load.
- It accepts one framed word of BUS_WIDTH bits, one bit per enabled cycle, in MSB-first or LSB-first order.
- It assembles the bits in an internal shift register and presents the completed word on a parallel output with a valid/ready handshake.
- It sits between a serial line front end and the word-level consumer logic.

---
 rtl/serial_parallel_receiver_if.sv | 35 +++
 rtl/serial_parallel_receiver.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_parallel_receiver_if.sv
// Bus between a serial line front end (master) and serial_parallel_receiver (slave).
// Optional parity output is present when SERIAL_RX_PARITY_EN is defined.
interface serial_parallel_receiver_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 start_i;
  logic                 bit_en_i;
  logic                 serial_i;
  logic                 msb_first_i;
  logic                 ready_i;
  logic                 clear_i;
  logic [BUS_WIDTH-1:0] data_o;
  logic                 valid_o;
  logic                 busy_o;
  logic                 overrun_o;
`ifdef SERIAL_RX_PARITY_EN
  logic                 parity_err_o;
`endif

  modport master (
    output start_i, bit_en_i, serial_i, msb_first_i, ready_i, clear_i,
`ifdef SERIAL_RX_PARITY_EN
    input  parity_err_o,
`endif
    input  data_o, valid_o, busy_o, overrun_o
  );

  modport slave (
    input  start_i, bit_en_i, serial_i, msb_first_i, ready_i, clear_i,
`ifdef SERIAL_RX_PARITY_EN
    output parity_err_o,
`endif
    output data_o, valid_o, busy_o, overrun_o
  );
endinterface

// File: rtl/serial_parallel_receiver.sv
// Serial-in / parallel-out receiver with valid/ready output handshake.
// Frames are BUS_WIDTH bits, MSB- or LSB-first, one bit per enabled cycle.
// Define SERIAL_RX_PARITY_EN to append an even-parity bit to each frame and
// expose parity_err_o.
module serial_parallel_receiver #(
  parameter int BUS_WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  serial_parallel_receiver_if.slave bus
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_LEN = BUS_WIDTH + 1;
`else
  localparam int FRAME_LEN = BUS_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(BUS_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [BUS_WIDTH-1:0] shreg;
  logic                 msb_first;
  logic [BUS_WIDTH-1:0] data_q;
  logic                 valid_q;
  logic                 overrun_q;
  logic                 take_bit;
  logic                 last_bit;
  logic                 load_word;
  logic                 drop_word;
`ifdef SERIAL_RX_PARITY_EN
  logic                 parity_bit;
  logic                 parity_err_q;
`endif

  // Insert one serial bit at the end selected by the latched bit order.
  function automatic logic [BUS_WIDTH-1:0] shift_in(
    input logic [BUS_WIDTH-1:0] cur,
    input logic                 bit_in,
    input logic                 msb_order
  );
    if (msb_order) return {cur[BUS_WIDTH-2:0], bit_in};
    else           return {bit_in, cur[BUS_WIDTH-1:1]};
  endfunction

  assign take_bit  = (state == RECV) && bus.bit_en_i;
  assign last_bit  = take_bit && (cnt == LAST_CNT);
  // A finished word is accepted unless an unconsumed word is still held.
  assign load_word = (state == DONE) && (!valid_q || bus.ready_i);
  assign drop_word = (state == DONE) && valid_q && !bus.ready_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = RECV;
      RECV:    if (last_bit)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame capture: latch bit order on start, then shift in enabled bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      cnt       <= '0;
      msb_first <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if ((state == IDLE) && bus.start_i) begin
      msb_first <= bus.msb_first_i;
      cnt       <= '0;
    end else if (take_bit) begin
      cnt <= cnt + CNT_ONE;
`ifdef SERIAL_RX_PARITY_EN
      if (cnt < DATA_CNT) shreg <= shift_in(shreg, bus.serial_i, msb_first);
      else                parity_bit <= bus.serial_i;
`else
      if (cnt < DATA_CNT) shreg <= shift_in(shreg, bus.serial_i, msb_first);
`endif
    end
  end

  // Output register and handshake; overrun is sticky and set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (load_word) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        parity_err_q <= ^shreg ^ parity_bit;
`endif
      end else if (valid_q && bus.ready_i) begin
        valid_q <= 1'b0;
      end
      if (drop_word)        overrun_q <= 1'b1;
      else if (bus.clear_i) overrun_q <= 1'b0;
    end
  end

  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.busy_o    = (state == RECV);
  assign bus.overrun_o = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  assign bus.parity_err_o = parity_err_q;
`endif

endmodule
